// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the FIFO width-down serializer.
//   ser_state_e   : IDLE (no word held) / SHIFT (word held, beats streaming)
//   ser_ratio     : number of narrow beats per input word
//   ser_cnt_w     : beat counter width (at least 1 bit)
//   ser_params_ok : legality of an IN_WIDTH/OUT_WIDTH pairing
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    function automatic int unsigned ser_ratio(input int unsigned in_w, input int unsigned out_w);
        return (out_w == 0) ? 0 : in_w / out_w;
    endfunction

    function automatic int unsigned ser_cnt_w(input int unsigned ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    function automatic bit ser_params_ok(input int unsigned in_w, input int unsigned out_w);
        return (out_w != 0) && ((in_w % out_w) == 0) && ((in_w / out_w) >= 2);
    endfunction

endpackage

// File: rtl/fifo_serializer.sv
// Width-down converter draining a first-word-fall-through FIFO: each IN_WIDTH
// word leaves as RATIO narrow beats with a last-beat marker.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   i__data_in_valid/_in  : word from FIFO
//   o__data_in_ready      : word consumed (combinational, only from out_ready + state)
//   o__data_out_valid/_out/_last : registered beat stream
//   i__data_out_ready     : downstream accepts beat
module fifo_serializer
    import fifo_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 64,
    parameter int unsigned OUT_WIDTH = 16,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i__data_in_valid,
    input  logic [IN_WIDTH-1:0]  i__data_in,
    output logic                 o__data_in_ready,
    output logic                 o__data_out_valid,
    output logic [OUT_WIDTH-1:0] o__data_out,
    output logic                 o__data_out_last,
    input  logic                 i__data_out_ready
);

    localparam int unsigned RATIO = ser_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned CNT_W = ser_cnt_w(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    // Reject illegal width pairings at elaboration.
    if (!ser_params_ok(IN_WIDTH, OUT_WIDTH)) begin : g_param_check
        $error("fifo_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end

    ser_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]  shreg_q, shreg_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 beat_xfer;
    logic                 load;

    // Ready is free in IDLE, or when the final beat is leaving this cycle.
    assign o__data_in_ready = (state_q == IDLE) || (last_q && i__data_out_ready);
    assign beat_xfer        = valid_q && i__data_out_ready;
    assign load             = i__data_in_valid && o__data_in_ready;

    // Current beat always sits at the shift-out end of the register.
    assign o__data_out       = MSB_FIRST ? shreg_q[IN_WIDTH-1 -: OUT_WIDTH]
                                         : shreg_q[OUT_WIDTH-1:0];
    assign o__data_out_valid = valid_q;
    assign o__data_out_last  = last_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Next-state: a load (from IDLE or on the final beat) takes priority,
    // otherwise a transferred beat advances the counter/shifter or ends the word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        valid_d = valid_q;
        last_d  = last_q;

        if (load) begin
            state_d = SHIFT;
            cnt_d   = '0;
            shreg_d = i__data_in;
            valid_d = 1'b1;
            last_d  = 1'b0;
        end else if (beat_xfer) begin
            if (last_q) begin
                state_d = IDLE;
                cnt_d   = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                shreg_d = MSB_FIRST ? (shreg_q << OUT_WIDTH) : (shreg_q >> OUT_WIDTH);
                last_d  = (cnt_d == LAST_CNT);
            end
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
module tb_fifo_serializer;

    localparam int R  = 4;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [63:0]   data_in;
    logic          out_ready;

    logic          rdy_l, vld_l, lst_l;
    logic [15:0]   dat_l;
    logic          rdy_m, vld_m, lst_m;
    logic [15:0]   dat_m;

    always #5 clk = ~clk;

    fifo_serializer #(.IN_WIDTH(64), .OUT_WIDTH(16), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset),
        .i__data_in_valid(in_valid), .i__data_in(data_in), .o__data_in_ready(rdy_l),
        .o__data_out_valid(vld_l), .o__data_out(dat_l), .o__data_out_last(lst_l),
        .i__data_out_ready(out_ready)
    );

    fifo_serializer #(.IN_WIDTH(64), .OUT_WIDTH(16), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset),
        .i__data_in_valid(in_valid), .i__data_in(data_in), .o__data_in_ready(rdy_m),
        .o__data_out_valid(vld_m), .o__data_out(dat_m), .o__data_out_last(lst_m),
        .i__data_out_ready(out_ready)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a held word and the index of the beat on offer.
    logic        m_held;
    logic [63:0] m_word;
    int          m_k;
    wire         m_rdy = !m_held || ((m_k == R - 1) && out_ready);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_held <= 1'b0;
            m_k    <= 0;
            m_word <= '0;
        end else if (in_valid && m_rdy) begin
            m_held <= 1'b1;
            m_word <= data_in;
            m_k    <= 0;
        end else if (m_held && out_ready) begin
            if (m_k == R - 1) m_held <= 1'b0;
            else              m_k    <= m_k + 1;
        end
    end

    // Transfer log for the directed expectations.
    logic [15:0] xq_l[$];
    logic [15:0] xq_m[$];
    int          xcyc[$];
    int          rb[$];
    int          cyc = 0;
    int          beat_no = 0;

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        #2;
        chk("ready_l", 64'(rdy_l), 64'(m_rdy));
        chk("ready_m", 64'(rdy_m), 64'(m_rdy));
        chk("valid_l", 64'(vld_l), 64'(m_held));
        chk("valid_m", 64'(vld_m), 64'(m_held));
        if (m_held) begin
            chk("last_l", 64'(lst_l), 64'(m_k == R - 1));
            chk("last_m", 64'(lst_m), 64'(m_k == R - 1));
            chk("data_l", 64'(dat_l), 64'(m_word[m_k*OW +: OW]));
            chk("data_m", 64'(dat_m), 64'(m_word[(R-1-m_k)*OW +: OW]));
        end
        if (vld_l && out_ready) begin
            xq_l.push_back(dat_l);
            xq_m.push_back(dat_m);
            xcyc.push_back(cyc);
            if (rdy_l) rb.push_back(beat_no);
            beat_no++;
        end
        cyc++;
    end

    // FIFO-like source: word stays offered until handshaken.
    logic [63:0] src[$];
    bit          hs = 1'b0;

    task automatic cycle(input bit ordy);
        logic [63:0] tmp;
        @(negedge clk);
        if (hs && src.size() != 0) tmp = src.pop_front();
        hs        = 1'b0;
        in_valid  = (src.size() != 0);
        data_in   = in_valid ? src[0] : 64'h0;
        out_ready = ordy;
        #1;
        hs = in_valid && rdy_l;
    endtask

    task automatic clear_log();
        xq_l.delete(); xq_m.delete(); xcyc.delete(); rb.delete();
        beat_no = 0;
    endtask

    function automatic logic [15:0] qget(input logic [15:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 16'h0;
    endfunction

    function automatic int iget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic expect4(input string nm, input logic [15:0] q[$], input int base,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        chk(nm, 64'(qget(q, base)),     64'(a));
        chk(nm, 64'(qget(q, base + 1)), 64'(b));
        chk(nm, 64'(qget(q, base + 2)), 64'(c));
        chk(nm, 64'(qget(q, base + 3)), 64'(d));
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        #1;
        chk("rst_valid", 64'(vld_l), 64'h0);
        chk("rst_data",  64'(dat_l), 64'h0);
        chk("rst_last",  64'(lst_l), 64'h0);
        chk("rst_ready", 64'(rdy_l), 64'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single word, LSB first.
        clear_log();
        src.push_back(64'h4444_3333_2222_1111);
        repeat (6) cycle(1'b1);
        #3;
        chk("t1_len", 64'(xq_l.size()), 64'd4);
        expect4("t1_beats", xq_l, 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        chk("t1_rdy_cnt", 64'(rb.size()), 64'd1);
        chk("t1_rdy_beat", 64'(iget(rb, 0)), 64'd3);

        // Back-to-back: three words, twelve beats with no gaps.
        clear_log();
        src.push_back(64'h0003_0002_0001_0000);
        src.push_back(64'h0007_0006_0005_0004);
        src.push_back(64'h000B_000A_0009_0008);
        repeat (15) cycle(1'b1);
        #3;
        chk("t2_len", 64'(xq_l.size()), 64'd12);
        for (int i = 0; i < 12; i++) chk("t2_beat", 64'(qget(xq_l, i)), 64'(i));
        chk("t2_span", 64'(iget(xcyc, 11) - iget(xcyc, 0)), 64'd11);
        chk("t2_rdy_cnt", 64'(rb.size()), 64'd3);
        chk("t2_rdy_b0", 64'(iget(rb, 0)), 64'd3);
        chk("t2_rdy_b1", 64'(iget(rb, 1)), 64'd7);
        chk("t2_rdy_b2", 64'(iget(rb, 2)), 64'd11);

        // Backpressure pattern 1,0,0,1,...
        clear_log();
        src.push_back(64'hDEAD_BEEF_CAFE_F00D);
        cycle(1'b1);
        for (int i = 0; i < 10; i++) cycle((i % 3) == 0);
        repeat (2) cycle(1'b1);
        #3;
        chk("t3_len", 64'(xq_l.size()), 64'd4);
        expect4("t3_beats", xq_l, 0, 16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD);

        // Beat order of both orientations.
        clear_log();
        src.push_back(64'hAAAA_BBBB_CCCC_DDDD);
        repeat (6) cycle(1'b1);
        #3;
        chk("t4_len", 64'(xq_m.size()), 64'd4);
        expect4("t4_msb", xq_m, 0, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        expect4("t4_lsb", xq_l, 0, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA);

        // Asynchronous reset after beat 1 of a word.
        clear_log();
        src.push_back(64'h1234_5678_9ABC_DEF0);
        repeat (3) cycle(1'b1);
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("t5_valid_l", 64'(vld_l), 64'h0);
        chk("t5_valid_m", 64'(vld_m), 64'h0);
        chk("t5_ready",   64'(rdy_l), 64'h1);
        chk("t5_last",    64'(lst_l), 64'h0);
        src.delete();
        hs       = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #3;
        chk("t5_post_ready", 64'(rdy_l), 64'h1);
        chk("t5_post_valid", 64'(vld_l), 64'h0);
        clear_log();
        src.push_back(64'h8888_7777_6666_5555);
        repeat (6) cycle(1'b1);
        #3;
        chk("t5_len", 64'(xq_l.size()), 64'd4);
        expect4("t5_beats", xq_l, 0, 16'h5555, 16'h6666, 16'h7777, 16'h8888);

        // Last beat stalled with next word waiting.
        clear_log();
        src.push_back(64'h0103_0102_0101_0100);
        src.push_back(64'h0203_0202_0201_0200);
        repeat (4) cycle(1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            chk("t6_in_valid", 64'(in_valid), 64'h1);
            chk("t6_stall_rdy", 64'(rdy_l), 64'h0);
            chk("t6_stall_dat", 64'(dat_l), 64'h0103);
        end
        repeat (6) cycle(1'b1);
        #3;
        chk("t6_len", 64'(xq_l.size()), 64'd8);
        expect4("t6_w1", xq_l, 0, 16'h0100, 16'h0101, 16'h0102, 16'h0103);
        expect4("t6_w2", xq_l, 4, 16'h0200, 16'h0201, 16'h0202, 16'h0203);
        chk("t6_rdy_cnt", 64'(rb.size()), 64'd2);
        chk("t6_rdy_b0", 64'(iget(rb, 0)), 64'd3);
        chk("t6_rdy_b1", 64'(iget(rb, 1)), 64'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
